// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encodings and 8N1 frame constants.
// The matching transmitter imports the same package.
package uart_pkg;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;
    localparam int IDX_W     = $clog2(DATA_BITS);
    localparam int CNT_W     = 16;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        CLEANUP   = 3'd4,
        WAIT_IDLE = 3'd5
    } uart_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// Serial input plus the received-byte outputs of the UART receiver.
interface uart_rx_if;
    import uart_pkg::*;

    logic                 i_Rx_Serial;
    logic                 o_Rx_DV;
    logic [DATA_BITS-1:0] o_Rx_Byte;
    logic                 o_Rx_Frame_Err;
    logic                 o_Rx_Active;

    modport slave  (input  i_Rx_Serial,
                    output o_Rx_DV, o_Rx_Byte, o_Rx_Frame_Err, o_Rx_Active);
    modport master (output i_Rx_Serial,
                    input  o_Rx_DV, o_Rx_Byte, o_Rx_Frame_Err, o_Rx_Active);

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; both flops reset to RESET_VAL.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic i_Clock,
    input  logic i_Reset,
    input  logic i_D,
    output logic o_Q
);

    logic r_Meta;

    // NOTE: non-blocking assignments keep r_Meta and o_Q as two distinct flops.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_Meta <= RESET_VAL;
            o_Q    <= RESET_VAL;
        end else begin
            r_Meta <= i_D;
            o_Q    <= r_Meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling off a synchronized line, one-cycle DV or
// frame-error pulse per frame, and a wait-for-idle guard after a framing error.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic     i_Clock,
    input  logic     i_Reset,
    uart_rx_if.slave rx_bus
);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);

    logic                 w_Rx_Sync;
    uart_state_t          r_State;
    logic [CNT_W-1:0]     r_Clk_Count;
    logic [IDX_W-1:0]     r_Bit_Index;
    logic [DATA_BITS-1:0] r_Rx_Data;
    logic [DATA_BITS-1:0] r_Rx_Byte;
    logic                 r_Rx_DV;
    logic                 r_Rx_Frame_Err;
    logic                 r_Rx_Active;

    sync_2ff #(.RESET_VAL(1'b1)) u_sync (
        .i_Clock (i_Clock),
        .i_Reset (i_Reset),
        .i_D     (rx_bus.i_Rx_Serial),
        .o_Q     (w_Rx_Sync)
    );

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_State        <= IDLE;
            r_Clk_Count    <= '0;
            r_Bit_Index    <= '0;
            r_Rx_Data      <= '0;
            r_Rx_Byte      <= '0;
            r_Rx_DV        <= 1'b0;
            r_Rx_Frame_Err <= 1'b0;
            r_Rx_Active    <= 1'b0;
        end else begin
            // NOTE: pulse outputs default low every cycle so each lasts exactly one clock.
            r_Rx_DV        <= 1'b0;
            r_Rx_Frame_Err <= 1'b0;

            case (r_State)
                IDLE: begin
                    r_Clk_Count <= '0;
                    r_Bit_Index <= '0;
                    if (!w_Rx_Sync)
                        r_State <= START;
                end

                START: begin
                    if (r_Clk_Count == HALF_LAST) begin
                        r_Clk_Count <= '0;
                        if (!w_Rx_Sync) begin
                            r_Rx_Active <= 1'b1;
                            r_State     <= DATA;
                        end else begin
                            r_State     <= IDLE;
                        end
                    end else begin
                        r_Clk_Count <= r_Clk_Count + CNT_W'(1);
                    end
                end

                DATA: begin
                    if (r_Clk_Count < BIT_LAST) begin
                        r_Clk_Count <= r_Clk_Count + CNT_W'(1);
                    end else begin
                        r_Clk_Count            <= '0;
                        r_Rx_Data[r_Bit_Index] <= w_Rx_Sync;
                        if (r_Bit_Index == LAST_IDX) begin
                            r_Bit_Index <= '0;
                            r_State     <= STOP;
                        end else begin
                            r_Bit_Index <= r_Bit_Index + IDX_W'(1);
                        end
                    end
                end

                STOP: begin
                    if (r_Clk_Count < BIT_LAST) begin
                        r_Clk_Count <= r_Clk_Count + CNT_W'(1);
                    end else begin
                        r_Clk_Count <= '0;
                        r_Rx_Active <= 1'b0;
                        if (w_Rx_Sync) begin
                            r_Rx_Byte <= r_Rx_Data;
                            r_Rx_DV   <= 1'b1;
                        end else begin
                            r_Rx_Frame_Err <= 1'b1;
                        end
                        r_State <= CLEANUP;
                    end
                end

                // The error pulse is still high here, so it selects the exit path.
                CLEANUP: begin
                    r_State <= r_Rx_Frame_Err ? WAIT_IDLE : IDLE;
                end

                WAIT_IDLE: begin
                    if (w_Rx_Sync)
                        r_State <= IDLE;
                end

                default: begin
                    r_State     <= IDLE;
                    r_Clk_Count <= '0;
                    r_Bit_Index <= '0;
                    r_Rx_Active <= 1'b0;
                end
            endcase
        end
    end

    assign rx_bus.o_Rx_DV        = r_Rx_DV;
    assign rx_bus.o_Rx_Byte      = r_Rx_Byte;
    assign rx_bus.o_Rx_Frame_Err = r_Rx_Frame_Err;
    assign rx_bus.o_Rx_Active    = r_Rx_Active;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit: reset, single frame, glitch,
// framing error with stuck-low line, back-to-back frames, mid-frame reset, timing skew.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int CPB = 16;

    logic i_Clock = 1'b0;
    logic i_Reset;

    uart_rx_if rx_if ();

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .i_Clock (i_Clock),
        .i_Reset (i_Reset),
        .rx_bus  (rx_if)
    );

    always #5 i_Clock = ~i_Clock;

    int checks = 0;
    int errors = 0;

    int unsigned cycle = 0;
    always @(posedge i_Clock) cycle <= cycle + 1;

    // Output monitor, sampled on the falling edge.
    int          dv_count      = 0;
    int          fe_count      = 0;
    int          active_cycles = 0;
    int          overlap_count = 0;
    int          wide_count    = 0;
    int unsigned last_dv_cycle = 0;
    logic        prev_dv       = 1'b0;
    logic        prev_fe       = 1'b0;
    logic [7:0]  dv_bytes[$];

    always @(negedge i_Clock) begin
        if (rx_if.o_Rx_DV) begin
            dv_count      <= dv_count + 1;
            last_dv_cycle <= cycle;
            dv_bytes.push_back(rx_if.o_Rx_Byte);
        end
        if (rx_if.o_Rx_Frame_Err)                 fe_count      <= fe_count + 1;
        if (rx_if.o_Rx_Active)                    active_cycles <= active_cycles + 1;
        if (rx_if.o_Rx_DV && rx_if.o_Rx_Frame_Err) overlap_count <= overlap_count + 1;
        if ((rx_if.o_Rx_DV && prev_dv) || (rx_if.o_Rx_Frame_Err && prev_fe))
            wide_count <= wide_count + 1;
        prev_dv <= rx_if.o_Rx_DV;
        prev_fe <= rx_if.o_Rx_Frame_Err;
    end

    // Drives one frame starting at a falling clock edge; the first five bit slots
    // last p_first clocks, the remaining slots p_second clocks.
    task automatic send_frame(input logic [7:0] data, input logic stop_val,
                              input int p_first, input int p_second);
        for (int i = 0; i < 1 + DATA_BITS + STOP_BITS; i++) begin
            if (i == 0)              rx_if.i_Rx_Serial = 1'b0;
            else if (i <= DATA_BITS) rx_if.i_Rx_Serial = data[i-1];
            else                     rx_if.i_Rx_Serial = stop_val;
            repeat ((i < 5) ? p_first : p_second) @(negedge i_Clock);
        end
    endtask

    task automatic idle_bits(input int n);
        rx_if.i_Rx_Serial = 1'b1;
        repeat (n * CPB) @(negedge i_Clock);
        #1;
    endtask

    task automatic test_reset;
        rx_if.i_Rx_Serial = 1'b1;
        i_Reset = 1'b1;
        repeat (3) @(negedge i_Clock);
        checks++; if (rx_if.o_Rx_DV !== 1'b0) begin errors++; $display("FAIL reset_dv: got %b expected 0", rx_if.o_Rx_DV); end
        checks++; if (rx_if.o_Rx_Frame_Err !== 1'b0) begin errors++; $display("FAIL reset_fe: got %b expected 0", rx_if.o_Rx_Frame_Err); end
        checks++; if (rx_if.o_Rx_Active !== 1'b0) begin errors++; $display("FAIL reset_active: got %b expected 0", rx_if.o_Rx_Active); end
        checks++; if (rx_if.o_Rx_Byte !== 8'h00) begin errors++; $display("FAIL reset_byte: got %h expected 00", rx_if.o_Rx_Byte); end
        checks++; if (dut.r_State !== IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", dut.r_State, IDLE); end
        i_Reset = 1'b0;
        idle_bits(2);
    endtask

    task automatic test_single_frame;
        int d0, f0, a0;
        int unsigned t0;
        d0 = dv_count; f0 = fe_count; a0 = active_cycles;
        @(negedge i_Clock);
        t0 = cycle;
        send_frame(8'hA5, 1'b1, CPB, CPB);
        idle_bits(1);
        checks++; if (dv_count - d0 !== 1) begin errors++; $display("FAIL single_dv_count: got %0d expected 1", dv_count - d0); end
        checks++; if (dv_bytes[$] !== 8'hA5) begin errors++; $display("FAIL single_dv_byte: got %h expected a5", dv_bytes[$]); end
        checks++; if (rx_if.o_Rx_Byte !== 8'hA5) begin errors++; $display("FAIL single_byte_hold: got %h expected a5", rx_if.o_Rx_Byte); end
        checks++; if (fe_count - f0 !== 0) begin errors++; $display("FAIL single_fe: got %0d expected 0", fe_count - f0); end
        // 2 + 7 + 9*16 + 1 = 154 cycles, within one cycle either way.
        checks++; if (last_dv_cycle - t0 < 153 || last_dv_cycle - t0 > 155) begin errors++; $display("FAIL single_latency: got %0d expected 153..155", last_dv_cycle - t0); end
        checks++; if (active_cycles - a0 !== 9 * CPB) begin errors++; $display("FAIL single_active_len: got %0d expected %0d", active_cycles - a0, 9 * CPB); end
    endtask

    task automatic test_glitch;
        int d0, f0, a0;
        d0 = dv_count; f0 = fe_count; a0 = active_cycles;
        @(negedge i_Clock);
        rx_if.i_Rx_Serial = 1'b0;
        repeat (5) @(negedge i_Clock);
        idle_bits(3);
        checks++; if (dv_count - d0 !== 0) begin errors++; $display("FAIL glitch_dv: got %0d expected 0", dv_count - d0); end
        checks++; if (fe_count - f0 !== 0) begin errors++; $display("FAIL glitch_fe: got %0d expected 0", fe_count - f0); end
        checks++; if (active_cycles - a0 !== 0) begin errors++; $display("FAIL glitch_active: got %0d expected 0", active_cycles - a0); end
        checks++; if (dut.r_State !== IDLE) begin errors++; $display("FAIL glitch_state: got %0d expected %0d", dut.r_State, IDLE); end
    endtask

    task automatic test_frame_error;
        int d0, f0;
        d0 = dv_count; f0 = fe_count;
        @(negedge i_Clock);
        send_frame(8'h3C, 1'b0, CPB, CPB);
        repeat (40 * CPB) @(negedge i_Clock);
        #1;
        checks++; if (fe_count - f0 !== 1) begin errors++; $display("FAIL ferr_count: got %0d expected 1", fe_count - f0); end
        checks++; if (dv_count - d0 !== 0) begin errors++; $display("FAIL ferr_dv: got %0d expected 0", dv_count - d0); end
        checks++; if (rx_if.o_Rx_Byte !== 8'hA5) begin errors++; $display("FAIL ferr_byte_kept: got %h expected a5", rx_if.o_Rx_Byte); end
        checks++; if (dut.r_State !== WAIT_IDLE) begin errors++; $display("FAIL ferr_state: got %0d expected %0d", dut.r_State, WAIT_IDLE); end
        idle_bits(1);
        @(negedge i_Clock);
        send_frame(8'h81, 1'b1, CPB, CPB);
        idle_bits(1);
        checks++; if (dv_count - d0 !== 1) begin errors++; $display("FAIL ferr_recover_dv: got %0d expected 1", dv_count - d0); end
        checks++; if (rx_if.o_Rx_Byte !== 8'h81) begin errors++; $display("FAIL ferr_recover_byte: got %h expected 81", rx_if.o_Rx_Byte); end
        checks++; if (fe_count - f0 !== 1) begin errors++; $display("FAIL ferr_single_pulse: got %0d expected 1", fe_count - f0); end
    endtask

    task automatic test_back_to_back;
        int d0, f0, q0;
        logic [7:0] exp_bytes [3];
        exp_bytes = '{8'h00, 8'hFF, 8'h55};
        d0 = dv_count; f0 = fe_count; q0 = dv_bytes.size();
        @(negedge i_Clock);
        for (int i = 0; i < 3; i++) send_frame(exp_bytes[i], 1'b1, CPB, CPB);
        idle_bits(1);
        checks++; if (dv_count - d0 !== 3) begin errors++; $display("FAIL b2b_dv_count: got %0d expected 3", dv_count - d0); end
        checks++; if (fe_count - f0 !== 0) begin errors++; $display("FAIL b2b_fe: got %0d expected 0", fe_count - f0); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (dv_bytes.size() <= q0 + i) begin
                errors++; $display("FAIL b2b_byte%0d: got none expected %h", i, exp_bytes[i]);
            end else if (dv_bytes[q0 + i] !== exp_bytes[i]) begin
                errors++; $display("FAIL b2b_byte%0d: got %h expected %h", i, dv_bytes[q0 + i], exp_bytes[i]);
            end
        end
    endtask

    task automatic test_reset_midframe;
        int d0, f0;
        d0 = dv_count; f0 = fe_count;
        @(negedge i_Clock);
        fork
            send_frame(8'hC3, 1'b1, CPB, CPB);
            begin
                // Middle of data bit 4 (bit slot 5).
                repeat (5 * CPB + 8) @(negedge i_Clock);
                checks++; if (rx_if.o_Rx_Active !== 1'b1) begin errors++; $display("FAIL midrst_active_before: got %b expected 1", rx_if.o_Rx_Active); end
                i_Reset = 1'b1;
                #1;
                checks++; if (rx_if.o_Rx_Active !== 1'b0) begin errors++; $display("FAIL midrst_active_async: got %b expected 0", rx_if.o_Rx_Active); end
                checks++; if (rx_if.o_Rx_Byte !== 8'h00) begin errors++; $display("FAIL midrst_byte_async: got %h expected 00", rx_if.o_Rx_Byte); end
                checks++; if (dut.r_State !== IDLE) begin errors++; $display("FAIL midrst_state_async: got %0d expected %0d", dut.r_State, IDLE); end
                // Release during data bit 6, where the line is high.
                repeat (2 * CPB) @(negedge i_Clock);
                i_Reset = 1'b0;
            end
        join
        idle_bits(1);
        checks++; if (dv_count - d0 !== 0) begin errors++; $display("FAIL midrst_dv: got %0d expected 0", dv_count - d0); end
        checks++; if (fe_count - f0 !== 0) begin errors++; $display("FAIL midrst_fe: got %0d expected 0", fe_count - f0); end
        @(negedge i_Clock);
        send_frame(8'h12, 1'b1, CPB, CPB);
        idle_bits(1);
        checks++; if (dv_count - d0 !== 1) begin errors++; $display("FAIL midrst_next_dv: got %0d expected 1", dv_count - d0); end
        checks++; if (rx_if.o_Rx_Byte !== 8'h12) begin errors++; $display("FAIL midrst_next_byte: got %h expected 12", rx_if.o_Rx_Byte); end
    endtask

    task automatic test_skew;
        int d0;
        d0 = dv_count;
        @(negedge i_Clock);
        send_frame(8'h96, 1'b1, 15, 17);
        idle_bits(1);
        checks++; if (dv_count - d0 !== 1) begin errors++; $display("FAIL skew15_dv: got %0d expected 1", dv_count - d0); end
        checks++; if (rx_if.o_Rx_Byte !== 8'h96) begin errors++; $display("FAIL skew15_byte: got %h expected 96", rx_if.o_Rx_Byte); end
        d0 = dv_count;
        @(negedge i_Clock);
        send_frame(8'h96, 1'b1, 17, 15);
        idle_bits(1);
        checks++; if (dv_count - d0 !== 1) begin errors++; $display("FAIL skew17_dv: got %0d expected 1", dv_count - d0); end
        checks++; if (rx_if.o_Rx_Byte !== 8'h96) begin errors++; $display("FAIL skew17_byte: got %h expected 96", rx_if.o_Rx_Byte); end
    endtask

    task automatic test_pulse_rules;
        checks++; if (overlap_count !== 0) begin errors++; $display("FAIL pulse_overlap: got %0d expected 0", overlap_count); end
        checks++; if (wide_count !== 0) begin errors++; $display("FAIL pulse_width: got %0d expected 0", wide_count); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_glitch();
        test_frame_error();
        test_back_to_back();
        test_reset_midframe();
        test_skew();
        test_pulse_rules();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 87, giving the number of i_Clock cycles per UART bit (legal range 8..65535).
REQ-002 SHALL have port i_Clock  input  1  the only clock; all state updates on its rising edge.
REQ-003 SHALL have port i_Reset  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port i_Rx_Serial  input  1  asynchronous serial line: idle high, 8N1 format, data LSB first.
REQ-005 SHALL have port o_Rx_DV  output  1  one-cycle pulse; o_Rx_Byte is valid on that cycle.
REQ-006 SHALL have port o_Rx_Byte  output  8  last correctly framed received byte.
REQ-007 SHALL have port o_Rx_Frame_Err  output  1  one-cycle pulse when the stop bit is sampled low.
REQ-008 SHALL have port o_Rx_Active  output  1  high from start-bit confirmation until the frame completes.

Function
REQ-009 SHALL pass i_Rx_Serial through a 2-flop synchronizer; both flops reset to 1, and all decisions use the second flop only.
REQ-010 SHALL implement these states: IDLE, START, DATA, STOP, CLEANUP, WAIT_IDLE.
REQ-011 IDLE: bit counter and clock counter held at 0; a synced low SHALL move the block to START.
REQ-012 START: count to (CLKS_PER_BIT-1)/2 (integer divide), then re-sample. If low, SHALL assert o_Rx_Active, clear the clock counter and go to DATA. If high, SHALL treat it as a glitch and return to IDLE with no output pulse.
REQ-013 DATA: after CLKS_PER_BIT-1 further cycles, SHALL sample one bit into shift position r_Bit_Index (LSB first) and clear the counter; after index 7 SHALL go to STOP.
REQ-014 STOP: after CLKS_PER_BIT-1 cycles, sample the line.
  - High: load o_Rx_Byte and pulse o_Rx_DV for exactly 1 cycle.
  - Low: pulse o_Rx_Frame_Err for 1 cycle and leave o_Rx_Byte unchanged.
  - Either way: deassert o_Rx_Active and go to CLEANUP.
REQ-015 CLEANUP: 1 cycle, then IDLE after a good stop bit or WAIT_IDLE after a frame error.
REQ-016 WAIT_IDLE: SHALL remain until the synced line is high, so a break or stuck-low line produces exactly one error and no further frames.
REQ-017 o_Rx_DV and o_Rx_Frame_Err SHALL never be high on the same cycle, and each SHALL be high for at most 1 cycle per frame.
REQ-018 Latency: o_Rx_DV SHALL assert 2 + (CLKS_PER_BIT-1)/2 + 9*CLKS_PER_BIT + 1 cycles (±1) after the falling edge at the pin.
REQ-019 The clock counter SHALL be at least 16 bits wide and SHALL never wrap within a bit period.
REQ-020 A new start edge arriving during CLEANUP SHALL be detected in IDLE on the next cycle; back-to-back frames with a single stop bit SHALL all be received.
REQ-021 Undefined state encodings SHALL go to IDLE on the next clock.

Reset
REQ-022 While i_Reset is high, all of the following SHALL hold immediately (asynchronous assertion):
  - state = IDLE;
  - counters = 0;
  - o_Rx_Byte = 8'h00;
  - o_Rx_DV = 0, o_Rx_Frame_Err = 0, o_Rx_Active = 0;
  - synchronizer flops = 1.
REQ-023 Reset asserted mid-frame SHALL abort the frame with no DV or error pulse. After release, the block SHALL wait for a fresh falling edge before receiving.

Structure
REQ-024 State encodings (3-bit) and the frame constants (data bits = 8, stop bits = 1) SHALL live in a shared uart_pkg, which the transmitter may also use.
REQ-025 The synchronizer SHALL be a separate sub-module, sync_2ff, with a reset-value parameter; all other logic SHALL be in a single always block plus output assigns.

Verification (CLKS_PER_BIT=16)
REQ-026 Drive byte 8'hA5, 8N1, at exactly 16 clocks/bit -> one o_Rx_DV pulse with o_Rx_Byte=8'hA5 and no frame error.
REQ-027 Drive a 5-cycle low glitch on an idle line -> no DV, no error, o_Rx_Active stays 0, and the block returns to IDLE.
REQ-028 Drive 8'h3C with the stop bit low, then hold the line low for 40 bit times, then send 8'h81 -> one o_Rx_Frame_Err, o_Rx_Byte keeps its prior value, then DV with 8'h81.
REQ-029 Drive 8'h00, 8'hFF and 8'h55 back-to-back with one stop bit each -> three DV pulses in that order with the correct bytes.
REQ-030 Assert i_Reset during data bit 4 of 8'hC3, release it, then send 8'h12 -> no output pulse for the aborted frame, then DV with 8'h12.
REQ-031 Send 8'h96 with the bit period skewed to 15 and then 17 clocks -> correct byte received in both cases.
